jtag_dr_bank: RTL
=================

// Module: jtag_dr_bank
// PURPOSE
//  Parametrised JTAG data-register bank behind the TAP controller and IR decoder.
//  Holds BYPASS, IDCODE, writable USERCODE and a full boundary-scan register (input + output cells per pin, global OE cell).
//  Selects the active DR from a one-hot instruction bus and drives the registered TDO.
//  Implements SAMPLE/PRELOAD, EXTEST, INTEST, CLAMP and HIGHZ pin control, with update latches.
// PARAMETERS
//  N_IO        4         boundary pins; BSR length = 2*N_IO+1
//  ID_W        32        IDCODE width
//  ID_VALUE    32'h0A1   IDCODE capture value; bit0 forced to 1 on capture
//  USER_W      8         USERCODE register width
//  USER_RESET  8'h99     USERCODE shadow value after reset
// PORTS
//  TCK         in   1         TAP clock; all state on posedge, TDO on negedge
//  TRST        in   1         asynchronous active-high reset
//  TDI         in   1         serial data in
//  CAPTUREDR   in   1         TAP Capture-DR state
//  SHIFTDR     in   1         TAP Shift-DR state
//  UPDATEDR    in   1         TAP Update-DR state
//  INSTR_SEL   in   9         one-hot selects, indices in jtag_pkg (BYPASS..HIGHZ)
//  CORE_OUT    in   N_IO      functional pin drive from core
//  CORE_OE     in   1         functional output enable from core
//  IO_IN       in   N_IO      pad input values
//  IO_OUT      out  N_IO      pad drive value
//  IO_OE       out  1         pad output enable
//  CORE_IN     out  N_IO      pad values presented to core
//  USER_REG    out  USER_W    USERCODE shadow (written on Update-DR)
//  TDO         out  1         serial data out, registered on negedge TCK
// BEHAVIOUR
//  Reset (TRST=1, async): shift chains, BSR update latches, bypass = 0; USER_REG = USER_RESET; TDO = 0.
//  DR select: exactly one INSTR_SEL bit -> that DR; zero or multiple bits -> BYPASS.
//   CLAMP and HIGHZ route the chain through BYPASS.
//  Capture (posedge TCK, CAPTUREDR=1):
//   - bypass <= 0
//   - id_sh <= {ID_VALUE[ID_W-1:1],1}
//   - user_sh <= USER_REG
//   - BSR <= {IO_OE cell, IO_OUT cells, IO_IN cells} = {IO_OE, IO_OUT, IO_IN}
//  Shift (SHIFTDR=1): selected DR shifts right. TDI enters MSB. TDO source = LSB.
//   Unselected DRs hold.
//  Update (UPDATEDR=1):
//   - USERCODE selected: USER_REG <= user_sh
//   - SAMPLE/EXTEST/INTEST selected: BSR out/OE cells copy to update latches
//   - otherwise latches hold
//  CAPTUREDR/SHIFTDR/UPDATEDR simultaneously high: priority Capture > Shift > Update.
//  TDO: on negedge TCK, TDO <= LSB of the selected DR.
//   TDO is 0 whenever SHIFTDR was low at the preceding posedge.
//  Pin muxing, combinational from latches and INSTR_SEL:
//   - EXTEST, CLAMP: IO_OUT/IO_OE from update latches
//   - HIGHZ: IO_OE=0, IO_OUT=latched value
//   - all other instructions: IO_OUT=CORE_OUT, IO_OE=CORE_OE
//   - INTEST: CORE_IN = input-cell update latches
//   - otherwise: CORE_IN = IO_IN
//  Latency:
//   - capture value appears at TDO on the first negedge after the capture posedge
//   - pin change takes effect on the Update-DR posedge
//  TRST mid-shift: chain contents are lost; pins revert to functional mode at once, because latches are cleared and no test instruction is selected after IR reset.
//  Shift length: bits shifted beyond the DR length fall out of the LSB. No wrap-around.
// STRUCTURE
//  jtag_pkg:
//   - SEL_* index constants: BYPASS=0, SAMPLE=1, EXTEST=2, INTEST=3, RUNBIST=4, CLAMP=5, IDCODE=6, USERCODE=7, HIGHZ=8
//   - INSTR_SEL width
//  Sub-module jtag_bsr_cell:
//   - one capture/shift flop plus update latch
//   - instantiated 2*N_IO+1 times with generate
//  Bypass, ID and user chains and the TDO mux stay inline.
// TESTING
//  1. TRST pulse mid-shift -> TDO=0, USER_REG=8'h99, IO_OUT=CORE_OUT, IO_OE=CORE_OE, all within the same cycle.
//  2. IDCODE select, capture + 32 shifts -> TDO serialises 32'h0A1 LSB-first (1,0,0,0,0,1,0,1,0...).
//  3. USERCODE: shift in 8'h3C, then Update-DR -> USER_REG=8'h3C.
//     Next capture + shift -> TDO reads 8'h3C.
//  4. EXTEST preload: shift 9'b1_1010_0000, then Update -> IO_OUT=4'hA, IO_OE=1. CORE_OUT changes are ignored.
//  5. HIGHZ after step 4 -> IO_OE=0. A 1-bit shift with TDI=1 delays TDO by exactly one TCK (bypass).
//  6. INSTR_SEL=9'b0 or 9'b001000001 -> bypass behaviour; capture shows TDO=0 first bit.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG data-register bank.
// Instruction-select indices, the select-bus width and the decoded-select payload.
package jtag_pkg;

  localparam int unsigned INSTR_W = 9;

  localparam int unsigned SEL_BYPASS   = 0;
  localparam int unsigned SEL_SAMPLE   = 1;
  localparam int unsigned SEL_EXTEST   = 2;
  localparam int unsigned SEL_INTEST   = 3;
  localparam int unsigned SEL_RUNBIST  = 4;
  localparam int unsigned SEL_CLAMP    = 5;
  localparam int unsigned SEL_IDCODE   = 6;
  localparam int unsigned SEL_USERCODE = 7;
  localparam int unsigned SEL_HIGHZ    = 8;

  typedef struct packed {
    logic bypass;
    logic idcode;
    logic usercode;
    logic bsr;
    logic pins_latched;
    logic highz;
    logic intest;
  } dr_sel_t;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [INSTR_W-1:0] v);
    return (v != '0) && ((v & (v - INSTR_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/jtag_bsr_cell.sv
// One boundary-scan cell: capture/shift flop plus its update latch.
module jtag_bsr_cell (
  input  logic clk,
  input  logic rst,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic cap_d,
  input  logic shift_d,
  output logic sh_q,
  output logic upd_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sh_q <= 1'b0;
    else if (capture_en) sh_q <= cap_d;
    else if (shift_en)   sh_q <= shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            upd_q <= 1'b0;
    else if (update_en) upd_q <= sh_q;
  end

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE, USERCODE and boundary scan,
// DR selection from a one-hot instruction bus, negedge TDO and pin muxing.
module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter int unsigned     N_IO       = 4,
  parameter int unsigned     ID_W       = 32,
  parameter logic [ID_W-1:0] ID_VALUE   = ID_W'(32'h0A1),
  parameter int unsigned     USER_W     = 8,
  parameter logic [USER_W-1:0] USER_RESET = USER_W'(8'h99)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TDI,
  input  logic               CAPTUREDR,
  input  logic               SHIFTDR,
  input  logic               UPDATEDR,
  input  logic [INSTR_W-1:0] INSTR_SEL,
  input  logic [N_IO-1:0]    CORE_OUT,
  input  logic               CORE_OE,
  input  logic [N_IO-1:0]    IO_IN,
  output logic [N_IO-1:0]    IO_OUT,
  output logic               IO_OE,
  output logic [N_IO-1:0]    CORE_IN,
  output logic [USER_W-1:0]  USER_REG,
  output logic               TDO
);

  localparam int unsigned BSR_W   = 2 * N_IO + 1;
  localparam int unsigned OUT_LSB = N_IO;
  localparam int unsigned OE_BIT  = 2 * N_IO;

  dr_sel_t           sel;
  logic              sel_ok;
  logic              cap_en, sh_en, upd_en;
  logic              bypass_q;
  logic [ID_W-1:0]   id_sh;
  logic [USER_W-1:0] user_sh;
  logic [BSR_W-1:0]  bsr_cap, bsr_next, bsr_sh, bsr_upd;
  logic              tdo_src;

  // Zero or multiple select bits fall back to BYPASS and functional pins.
  always_comb begin
    sel              = '0;
    sel_ok           = is_onehot(INSTR_SEL);
    sel.idcode       = sel_ok & INSTR_SEL[SEL_IDCODE];
    sel.usercode     = sel_ok & INSTR_SEL[SEL_USERCODE];
    sel.bsr          = sel_ok & (INSTR_SEL[SEL_SAMPLE] | INSTR_SEL[SEL_EXTEST] |
                                 INSTR_SEL[SEL_INTEST]);
    sel.pins_latched = sel_ok & (INSTR_SEL[SEL_EXTEST] | INSTR_SEL[SEL_CLAMP]);
    sel.highz        = sel_ok & INSTR_SEL[SEL_HIGHZ];
    sel.intest       = sel_ok & INSTR_SEL[SEL_INTEST];
    sel.bypass       = ~(sel.idcode | sel.usercode | sel.bsr);
  end

  // Capture wins over shift, shift over update.
  assign cap_en = CAPTUREDR;
  assign sh_en  = SHIFTDR & ~CAPTUREDR;
  assign upd_en = UPDATEDR & ~CAPTUREDR & ~SHIFTDR;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)                       bypass_q <= 1'b0;
    else if (cap_en)                bypass_q <= 1'b0;
    else if (sh_en && sel.bypass)   bypass_q <= TDI;
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)                       id_sh <= '0;
    else if (cap_en)                id_sh <= {ID_VALUE[ID_W-1:1], 1'b1};
    else if (sh_en && sel.idcode)   id_sh <= {TDI, id_sh[ID_W-1:1]};
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)                       user_sh <= '0;
    else if (cap_en)                user_sh <= USER_REG;
    else if (sh_en && sel.usercode) user_sh <= {TDI, user_sh[USER_W-1:1]};
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)                       USER_REG <= USER_RESET;
    else if (upd_en && sel.usercode) USER_REG <= user_sh;
  end

  // Cell order from LSB: input cells, output cells, then the OE cell.
  assign bsr_cap  = {IO_OE, IO_OUT, IO_IN};
  assign bsr_next = {TDI, bsr_sh[BSR_W-1:1]};

  for (genvar i = 0; i < BSR_W; i++) begin : g_bsr
    jtag_bsr_cell u_cell (
      .clk        (TCK),
      .rst        (TRST),
      .capture_en (cap_en),
      .shift_en   (sh_en & sel.bsr),
      .update_en  (upd_en & sel.bsr),
      .cap_d      (bsr_cap[i]),
      .shift_d    (bsr_next[i]),
      .sh_q       (bsr_sh[i]),
      .upd_q      (bsr_upd[i])
    );
  end

  always_comb begin
    IO_OUT  = CORE_OUT;
    IO_OE   = CORE_OE;
    CORE_IN = IO_IN;
    if (sel.pins_latched) begin
      IO_OUT = bsr_upd[OUT_LSB +: N_IO];
      IO_OE  = bsr_upd[OE_BIT];
    end else if (sel.highz) begin
      IO_OUT = bsr_upd[OUT_LSB +: N_IO];
      IO_OE  = 1'b0;
    end
    if (sel.intest) CORE_IN = bsr_upd[N_IO-1:0];
  end

  always_comb begin
    tdo_src = bypass_q;
    if (sel.idcode)        tdo_src = id_sh[0];
    else if (sel.usercode) tdo_src = user_sh[0];
    else if (sel.bsr)      tdo_src = bsr_sh[0];
  end

  // TDO only carries data while the TAP sits in Shift-DR.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) TDO <= 1'b0;
    else      TDO <= SHIFTDR & tdo_src;
  end

endmodule
